// File: rtl/vga_pkg.sv
// Shared VGA raster types, default 640x480@60 timing and total-period helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  // Default 640x480@60 timing (25 MHz pixel rate).
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Scan coordinate, shared with the sprite renderers.
  typedef logic [COORD_W-1:0] coord_t;
  // One DAC colour channel.
  typedef logic [7:0] chan_t;

  // Full period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned axis_total(input int unsigned act,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping axis counter: counts 0..TERMINAL on each enabled edge, then wraps to 0.
// Latency: count updates on the clk edge where en=1; wrap is combinational from the count.
// Backpressure: none; en=0 holds the count indefinitely.
// Ports: clk, rst_n (sync, active-low), en (advance), cnt (current count),
//        wrap (high while cnt sits at TERMINAL, i.e. the next enabled edge wraps).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter coord_t TERMINAL = coord_t'(799)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap
);

  coord_t cnt_q;
  coord_t cnt_d;

  assign wrap = (cnt_q == TERMINAL);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing and registered DAC output stage (RGB masked outside the active area).
// Latency: DAC outputs describe the counter position of the previous pix_en strobe (1 pixel).
// Backpressure: none; pix_en=0 freezes every register, line/frame pulses last one clk.
// Ports: clk, rst_n (sync, active-low), pix_en strobe, r_in/g_in/b_in renderer colour;
//        x_cnt/y_cnt scan position, active (comb), vga_r/g/b, vga_hs/vs (active low),
//        vga_blank_n, line_start/frame_start one-clk pulses.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic [7:0]         r_in,
  input  logic [7:0]         g_in,
  input  logic [7:0]         b_in,
  output logic [COORD_W-1:0] x_cnt,
  output logic [COORD_W-1:0] y_cnt,
  output logic               active,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic h_wrap;
  logic v_wrap;
  logic v_en;
  logic hs_raw;
  logic vs_raw;

  // The vertical counter only moves on the strobe that wraps the line.
  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .TERMINAL (coord_t'(H_TOTAL - 1))
  ) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .cnt   (x_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(
    .TERMINAL (coord_t'(V_TOTAL - 1))
  ) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_en),
    .cnt   (y_cnt),
    .wrap  (v_wrap)
  );

  assign active = (x_cnt < coord_t'(H_ACTIVE)) && (y_cnt < coord_t'(V_ACTIVE));
  assign hs_raw = !((x_cnt >= HS_FIRST) && (x_cnt <= HS_LAST));
  assign vs_raw = !((y_cnt >= VS_FIRST) && (y_cnt <= VS_LAST));

  chan_t r_q, r_d;
  chan_t g_q, g_d;
  chan_t b_q, b_d;
  logic  hs_q, hs_d;
  logic  vs_q, vs_d;
  logic  blank_n_q, blank_n_d;
  logic  line_start_q, line_start_d;
  logic  frame_start_q, frame_start_d;

  always_comb begin
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    // Pulses are one clk wide regardless of strobe spacing.
    line_start_d  = pix_en & h_wrap;
    frame_start_d = pix_en & h_wrap & v_wrap;
    if (pix_en) begin
      // Renderers may return junk off-screen; the DAC must see black there.
      r_d       = active ? r_in : '0;
      g_d       = active ? g_in : '0;
      b_d       = active ? b_in : '0;
      hs_d      = hs_raw;
      vs_d      = vs_raw;
      blank_n_d = active;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (30x17) so whole frames are cheap.
// Latency: expectations are queued at each strobe and popped one edge later.
// Backpressure: n/a.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [7:0] r_in, g_in, b_in;
  logic [9:0] x_cnt, y_cnt;
  logic       active;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, line_start, frame_start;

  always #10 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .x_cnt       (x_cnt),
    .y_cnt       (y_cnt),
    .active      (active),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  typedef struct {
    int x, y;
    bit act;
    int r, g, b;
    bit hs, vs, blank, ls, fs;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  exp_t rst_exp;

  int mx, my;
  int pat;
  int checks = 0;
  int errors = 0;

  int n_strobe, n_fs, n_ls, n_hs0, n_vs0, n_rgb, n_blank;
  int first_hs_x, fs_idx, fs_x, fs_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input int x, input int y, input int r, input int g, input int b);
    exp_t e;
    bit   act;
    act     = (x < HA) && (y < VA);
    e.ls    = (x == HT - 1);
    e.fs    = e.ls && (y == VT - 1);
    e.x     = e.ls ? 0 : x + 1;
    e.y     = e.ls ? ((y == VT - 1) ? 0 : y + 1) : y;
    e.act   = (e.x < HA) && (e.y < VA);
    e.r     = act ? r : 0;
    e.g     = act ? g : 0;
    e.b     = act ? b : 0;
    e.hs    = !((x >= HA + HF) && (x <= HA + HF + HS - 1));
    e.vs    = !((y >= VA + VF) && (y <= VA + VF + VS - 1));
    e.blank = act;
    return e;
  endfunction

  task automatic chk_out(input string ph, input exp_t e);
    chk({ph, " x_cnt"},       32'(x_cnt),       32'(e.x));
    chk({ph, " y_cnt"},       32'(y_cnt),       32'(e.y));
    chk({ph, " active"},      32'(active),      32'(e.act));
    chk({ph, " vga_r"},       32'(vga_r),       32'(e.r));
    chk({ph, " vga_g"},       32'(vga_g),       32'(e.g));
    chk({ph, " vga_b"},       32'(vga_b),       32'(e.b));
    chk({ph, " vga_hs"},      32'(vga_hs),      32'(e.hs));
    chk({ph, " vga_vs"},      32'(vga_vs),      32'(e.vs));
    chk({ph, " vga_blank_n"}, 32'(vga_blank_n), 32'(e.blank));
    chk({ph, " line_start"},  32'(line_start),  32'(e.ls));
    chk({ph, " frame_start"}, 32'(frame_start), 32'(e.fs));
  endtask

  task automatic clear_stats();
    n_strobe = 0; n_fs = 0; n_ls = 0; n_hs0 = 0; n_vs0 = 0; n_rgb = 0; n_blank = 0;
    first_hs_x = -1; fs_idx = -1; fs_x = -1; fs_y = -1;
  endtask

  // One pix_en strobe, then 'gap' idle clks during which everything must hold.
  task automatic strobe(input int gap);
    exp_t e;
    @(negedge clk);
    if (pat == 0) begin
      r_in = 8'hFF; g_in = 8'h00; b_in = 8'h80;
    end else begin
      // Renderer stand-in: colour derived from the live scan position.
      r_in = x_cnt[7:0]; g_in = ~x_cnt[7:0]; b_in = y_cnt[7:0];
    end
    pix_en = 1'b1;
    sb.push_back(predict(mx, my, int'(r_in), int'(g_in), int'(b_in)));
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    e = sb.pop_front();
    chk_out("strobe", e);
    n_strobe++;
    if (!vga_hs) begin
      n_hs0++;
      if (first_hs_x < 0) first_hs_x = mx;
    end
    if (!vga_vs) n_vs0++;
    if (line_start) n_ls++;
    if (frame_start) begin
      n_fs++; fs_idx = n_strobe; fs_x = int'(x_cnt); fs_y = int'(y_cnt);
    end
    if (vga_blank_n) n_blank++;
    if (vga_r == 8'hFF && vga_g == 8'h00 && vga_b == 8'h80) n_rgb++;
    mx = e.x;
    my = e.y;
    held = e;
    held.ls = 1'b0;
    held.fs = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      chk_out("hold", held);
    end
  endtask

  initial begin
    rst_exp = '{x: 0, y: 0, act: 1'b1, r: 0, g: 0, b: 0,
                hs: 1'b1, vs: 1'b1, blank: 1'b0, ls: 1'b0, fs: 1'b0};
    rst_n  = 1'b0;
    pix_en = 1'b0;
    r_in = 8'hFF; g_in = 8'h00; b_in = 8'h80;
    pat = 0;
    mx = 0; my = 0;

    // Reset state, including a strobe during reset (reset must win).
    repeat (2) @(posedge clk);
    @(negedge clk); pix_en = 1'b1;
    @(posedge clk); #1; pix_en = 1'b0;
    chk_out("reset", rst_exp);
    @(negedge clk); rst_n = 1'b1;

    // Frame 1: strobe every 2nd clk, constant colour for masking and sync counts.
    clear_stats();
    repeat (HT * VT) strobe(1);
    chk("frame_start count", 32'(n_fs), 32'(1));
    chk("frame_start strobe index", 32'(fs_idx), 32'(HT * VT));
    chk("frame_start x", 32'(fs_x), 32'(0));
    chk("frame_start y", 32'(fs_y), 32'(0));
    chk("line_start count", 32'(n_ls), 32'(VT));
    chk("hs low strobes", 32'(n_hs0), 32'(HS * VT));
    chk("hs first low x", 32'(first_hs_x), 32'(HA + HF));
    chk("vs low strobes", 32'(n_vs0), 32'(VS * HT));
    chk("masked rgb strobes", 32'(n_rgb), 32'(HA * VA));
    chk("blank_n high strobes", 32'(n_blank), 32'(HA * VA));

    // Frame 2: strobe every clk, colour follows position (alignment).
    pat = 1;
    clear_stats();
    repeat (HT * VT) strobe(0);
    chk("fast frame_start count", 32'(n_fs), 32'(1));
    chk("fast line_start count", 32'(n_ls), 32'(VT));

    // Stall at the pixel just before hsync.
    pat = 0;
    for (int i = 0; i < HT && mx != HA + HF - 2; i++) strobe(0);
    chk("stall approach x", 32'(x_cnt), 32'(HA + HF - 2));
    strobe(37);
    chk("stall frozen x", 32'(x_cnt), 32'(HA + HF - 1));
    strobe(0);
    chk("stall resume x", 32'(x_cnt), 32'(HA + HF));
    chk("stall hs still high", 32'(vga_hs), 32'(1));
    strobe(0);
    chk("stall hs now low", 32'(vga_hs), 32'(0));

    // Reset in the middle of hsync and vsync.
    for (int i = 0; i < HT * VT && !(mx == HA + HF + 2 && my == VA + VF + 1); i++) strobe(0);
    chk("midreset approach x", 32'(x_cnt), 32'(HA + HF + 2));
    chk("midreset approach y", 32'(y_cnt), 32'(VA + VF + 1));
    chk("midreset vs low", 32'(vga_vs), 32'(0));
    chk("midreset hs low", 32'(vga_hs), 32'(0));
    @(negedge clk); rst_n = 1'b0; pix_en = 1'b1;
    @(posedge clk); #1; pix_en = 1'b0;
    chk_out("midreset", rst_exp);
    @(negedge clk); rst_n = 1'b1;
    mx = 0; my = 0;

    // Full frame after reset: exactly one frame_start, at the very end.
    clear_stats();
    repeat (HT * VT) strobe(1);
    chk("post-reset frame_start count", 32'(n_fs), 32'(1));
    chk("post-reset frame_start index", 32'(fs_idx), 32'(HT * VT));
    chk("post-reset line_start count", 32'(n_ls), 32'(VT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

VGA raster timing generator and pixel output stage for the DE2-115 display path. It produces the `x_cnt`/`y_cnt` scan position consumed by every card sprite renderer. It accepts the OR-combined RGB those renderers return and drives the ADV7123 DAC pins with aligned, registered RGB, syncs and blanking. Default timing is 640x480@60: the 50 MHz board clock with a 25 MHz `pix_en` strobe.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock, 50 MHz
- `rst_n` in 1: synchronous active-low reset
- `pix_en` in 1: pixel-advance strobe, one `clk` wide
- `r_in`, `g_in`, `b_in` in 8 each: renderer colour for the current `x_cnt`/`y_cnt`
- `x_cnt` out 10: horizontal counter, 0..H_TOTAL-1
- `y_cnt` out 10: vertical counter, 0..V_TOTAL-1
- `active` out 1: combinational, `x_cnt<H_ACTIVE && y_cnt<V_ACTIVE`
- `vga_r`, `vga_g`, `vga_b` out 8 each: DAC colour
- `vga_hs` out 1: horizontal sync, active low
- `vga_vs` out 1: vertical sync, active low
- `vga_blank_n` out 1: DAC blank, low outside the active area
- `line_start` out 1: one-`clk` pulse at start of each line
- `frame_start` out 1: one-`clk` pulse at start of each frame

## Operation
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters change only on `clk` edges where `pix_en`=1. With `pix_en`=0, every register holds.
- Horizontal: `x_cnt` increments; at H_TOTAL-1 it wraps to 0 and `y_cnt` advances.
- Vertical: `y_cnt` wraps from V_TOTAL-1 to 0 in the same edge that `x_cnt` wraps.
- Sync decode, from the current counters:
  - hs_raw is low for `x_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
  - vs_raw is low for `y_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491].
- Output stage, on each `pix_en` edge:
  - `vga_hs`, `vga_vs` and `vga_blank_n` register hs_raw, vs_raw and `active`.
  - `vga_r/g/b` register `r_in/g_in/b_in` when `active`=1, else 0. Out-of-area renderer output is masked.
- Pulses: `line_start` is high for the single `clk` after the edge that sets `x_cnt` to 0. `frame_start` is the same, but only when `y_cnt` also becomes 0.
- Reset: `x_cnt`=0, `y_cnt`=0, `vga_r/g/b`=0, `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, `line_start`=0, `frame_start`=0.
  - Reset mid-line or mid-sync restarts the raster at (0,0) on the next edge with no partial pulse.
  - The first `frame_start` occurs only after a complete frame following reset.

## Timing
- Renderers are combinational from `x_cnt`/`y_cnt` and must settle within one `clk` (20 ns).
- `r_in` is sampled on the same `pix_en` edge that advances the counters.
- Latency: DAC outputs describe the position held by the counters before each `pix_en` edge, one pixel late. RGB, syncs and blank are mutually aligned.
- `pix_en` asserted every cycle is legal (simulation speed-up); the raster then runs at `clk` rate.
- `pix_en` gaps of any length are legal: every output holds until the next strobe.
- Simultaneous `rst_n`=0 and `pix_en`=1: reset wins.
- Line period: H_TOTAL strobes. Frame period: H_TOTAL*V_TOTAL = 420000 strobes.

## Structure
- Package `vga_pkg`:
  - default timing localparams, and H_TOTAL/V_TOTAL as functions of the parameters
  - 10-bit coordinate typedef `coord_t`, shared with the sprite renderers
  - 8-bit `chan_t`
- Sub-module `vga_axis_counter`: parameterised wrap counter with `en` input, `wrap` output and terminal value. Instantiated twice.
  - horizontal: enabled by `pix_en`
  - vertical: enabled by `pix_en & h_wrap`

## Test plan
- Reset, then `pix_en` every 2nd `clk` for one frame:
  - `frame_start` is seen once, at x=0/y=0 after 420000 strobes.
  - `line_start` is seen 525 times.
- Sync widths: count strobes with `vga_hs`=0 → exactly 96 per line, first at registered x=656. Count lines with `vga_vs`=0 → 2 per frame, lines 490-491.
- Masking: drive constant `r_in`=FF, `g_in`=00, `b_in`=80.
  - `vga_r/g/b`=FF/00/80 for exactly 640x480 strobes per frame, 0 elsewhere.
  - `vga_blank_n` matches this window.
- Alignment: `r_in`=`x_cnt[7:0]` → at each strobe, `vga_r` equals the `x_cnt` value from the previous strobe, for active x.
- Stall: hold `pix_en`=0 for 37 clks at x=655 → all outputs frozen. Next strobe gives x=656 and `vga_hs` still 1; the following strobe gives `vga_hs`=0.
- Reset mid-frame at x=700/y=491 (vs low):
  - Next clk: counters 0, `vga_hs`=`vga_vs`=1, `vga_blank_n`=0, no pulses.
  - The raster resumes from (0,0).
